// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM stage: funct3 access sizes, stage state and
// byte-strobe base patterns.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B   = 3'b000;
   localparam logic [2:0] F3_H   = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BU  = 3'b100;
   localparam logic [2:0] F3_HU  = 3'b101;
   localparam logic [2:0] F3_WU  = 3'b110;
   localparam logic [2:0] F3_ILL = 3'b111;

   localparam logic [7:0] STRB_B = 8'h01;
   localparam logic [7:0] STRB_H = 8'h03;
   localparam logic [7:0] STRB_W = 8'h0F;
   localparam logic [7:0] STRB_D = 8'hFF;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

   // Strobe pattern for an access of the given size, before lane shifting.
   function automatic logic [7:0] strb_base(input logic [1:0] size);
      case (size)
         2'b00:   return STRB_B;
         2'b01:   return STRB_H;
         2'b10:   return STRB_W;
         default: return STRB_D;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data extraction and access legality for one 64-bit bus word:
// right-aligns the addressed lane and sign/zero-extends by funct3.
module mem_load_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [2:0]  lane,
   input  logic [63:0] rdata,
   output logic [63:0] load_data,
   output logic        legal
);

   logic [63:0] shifted;

   assign shifted = rdata >> {lane, 3'b000};

   always_comb begin
      load_data = '0;
      legal     = 1'b0;
      case (funct3)
         F3_B:  begin load_data = {{56{shifted[7]}},  shifted[7:0]};  legal = 1'b1; end
         F3_H:  begin load_data = {{48{shifted[15]}}, shifted[15:0]}; legal = ~lane[0]; end
         F3_W:  begin load_data = {{32{shifted[31]}}, shifted[31:0]}; legal = (lane[1:0] == 2'b00); end
         F3_D:  begin load_data = shifted;                            legal = (lane == 3'b000); end
         F3_BU: begin load_data = {56'd0, shifted[7:0]};              legal = 1'b1; end
         F3_HU: begin load_data = {48'd0, shifted[15:0]};             legal = ~lane[0]; end
         F3_WU: begin load_data = {32'd0, shifted[31:0]};             legal = (lane[1:0] == 2'b00); end
         F3_ILL: begin load_data = '0;                                legal = 1'b0; end
         default: begin load_data = '0;                               legal = 1'b0; end
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns loads/stores into single-beat req/ack bus
// accesses, stalling upstream until the access completes or times out.
module mem_access_stage
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter int unsigned DATA_W      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [4:0]        rd_in,
   input  logic [2:0]        funct3_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              RegWrite_in,
   input  logic              MemtoReg_in,
   output logic              stall_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [4:0]        rd_out,
   output logic              RegWrite_out,
   output logic              MemtoReg_out,
   output logic              misaligned_out,
   output logic              bus_error_out,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [7:0]        dmem_wstrb,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata
);

   localparam logic [9:0] TIMEOUT_CNT = 10'(ACK_TIMEOUT);

   mem_state_t  state;
   logic [9:0]  cnt;
   logic [9:0]  cnt_nxt;
   logic [63:0] load_buf;
   logic        err_q;
   logic        mem_op;
   logic        align_ok;
   logic        access_ok;
   logic [63:0] load_ext;

   mem_load_align u_align (
      .funct3    (funct3_in),
      .lane      (alu_result_in[2:0]),
      .rdata     (load_buf),
      .load_data (load_ext),
      .legal     (align_ok)
   );

   // Unsigned load encodings have no store counterpart.
   assign mem_op    = valid_in & (MemRead_in | MemWrite_in);
   assign access_ok = align_ok & ~(MemWrite_in & funct3_in[2]);
   assign cnt_nxt   = cnt + 10'd1;

   assign alu_result_out = alu_result_in;
   assign rd_out         = rd_in;
   assign MemtoReg_out   = MemtoReg_in;

   always_comb begin
      stall_out      = 1'b0;
      mem_data_out   = '0;
      RegWrite_out   = RegWrite_in;
      misaligned_out = 1'b0;
      bus_error_out  = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               RegWrite_out = 1'b0;
               if (access_ok) stall_out      = 1'b1;
               else           misaligned_out = 1'b1;
            end
         end
         BUSY: begin
            stall_out    = 1'b1;
            RegWrite_out = 1'b0;
         end
         DONE: begin
            if (MemRead_in) mem_data_out = load_ext;
            if (err_q) begin
               bus_error_out = 1'b1;
               RegWrite_out  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= '0;
         cnt        <= '0;
         load_buf   <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && access_ok) begin
                  dmem_addr  <= {alu_result_in[DATA_W-1:3], 3'b000};
                  dmem_we    <= MemWrite_in;
                  dmem_wdata <= store_data_in << {alu_result_in[2:0], 3'b000};
                  dmem_wstrb <= MemWrite_in ? (strb_base(funct3_in[1:0]) << alu_result_in[2:0]) : '0;
                  dmem_req   <= 1'b1;
                  cnt        <= '0;
                  err_q      <= 1'b0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               // An ack on the timeout edge still completes the access normally.
               if (dmem_ack) begin
                  load_buf   <= dmem_rdata;
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  dmem_wstrb <= '0;
                  state      <= DONE;
               end else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == TIMEOUT_CNT) begin
                     load_buf   <= '0;
                     err_q      <= 1'b1;
                     dmem_req   <= 1'b0;
                     dmem_we    <= 1'b0;
                     dmem_wstrb <= '0;
                     state      <= DONE;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short ack timeout so the
// timeout path and the ack-on-timeout-edge case are both reachable.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [63:0] alu_result_in;
   logic [63:0] store_data_in;
   logic [4:0]  rd_in;
   logic [2:0]  funct3_in;
   logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
   logic        stall_out;
   logic [63:0] mem_data_out;
   logic [63:0] alu_result_out;
   logic [4:0]  rd_out;
   logic        RegWrite_out, MemtoReg_out;
   logic        misaligned_out, bus_error_out;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;

   int total = 0;
   int bad   = 0;
   int stalls;
   logic        b_req, b_we;
   logic [63:0] b_addr, b_wdata;
   logic [7:0]  b_wstrb;

   always #5 clk = ~clk;

   mem_access_stage #(.ACK_TIMEOUT(4), .DATA_W(64)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .rd_in(rd_in), .funct3_in(funct3_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
      .stall_out(stall_out), .mem_data_out(mem_data_out),
      .alu_result_out(alu_result_out), .rd_out(rd_out),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .misaligned_out(misaligned_out), .bus_error_out(bus_error_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [4:0] rd);
      valid_in = v; MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw;
      MemtoReg_in = mr; funct3_in = f3; alu_result_in = addr;
      store_data_in = sdata; rd_in = rd;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
   endtask

   // Runs one stalled access; ack is raised in BUSY cycle (waits+1).
   task automatic run_access(input int waits, input logic give_ack,
                             input logic [63:0] rdata, output int n);
      n = 0;
      while (stall_out && n < 40) begin
         n++;
         dmem_ack   = give_ack && (n == waits + 2);
         dmem_rdata = rdata;
         tick();
         dmem_ack = 1'b0;
         if (n == 1) begin
            b_req = dmem_req; b_we = dmem_we; b_addr = dmem_addr;
            b_wdata = dmem_wdata; b_wstrb = dmem_wstrb;
         end
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
      bubble();
      #12;
      chk("rst_req",   {63'd0, dmem_req},      64'd0);
      chk("rst_wstrb", {56'd0, dmem_wstrb},    64'd0);
      chk("rst_stall", {63'd0, stall_out},     64'd0);
      chk("rst_berr",  {63'd0, bus_error_out}, 64'd0);
      reset = 1'b0;
      tick();

      // ADD passthrough
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 64'h1234, 64'd0, 5'd5);
      #1;
      chk("add_alu",   alu_result_out,        64'h1234);
      chk("add_rd",    {59'd0, rd_out},       64'd5);
      chk("add_rw",    {63'd0, RegWrite_out}, 64'd1);
      chk("add_stall", {63'd0, stall_out},    64'd0);
      tick();
      chk("add_req",   {63'd0, dmem_req},     64'd0);
      bubble();

      // LB, ack in first BUSY cycle
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 64'h1003, 64'd0, 5'd7);
      #1;
      chk("lb_rw_idle", {63'd0, RegWrite_out}, 64'd0);
      run_access(0, 1'b1, 64'h00000000_80000000, stalls);
      chk("lb_stalls", 64'(stalls),            64'd2);
      chk("lb_req",    {63'd0, b_req},         64'd1);
      chk("lb_addr",   b_addr,                 64'h1000);
      chk("lb_data",   mem_data_out,           64'hFFFFFFFF_FFFFFF80);
      chk("lb_rw",     {63'd0, RegWrite_out},  64'd1);
      chk("lb_req_dn", {63'd0, dmem_req},      64'd0);
      tick(); bubble();

      // LHU, 3 wait cycles; ack coincides with the timeout edge
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 64'h2006, 64'd0, 5'd8);
      #1;
      run_access(3, 1'b1, 64'hBEEF_1234_5678_9ABC, stalls);
      chk("lhu_stalls", 64'(stalls),           64'd5);
      chk("lhu_data",   mem_data_out,          64'h0000_0000_0000_BEEF);
      chk("lhu_berr",   {63'd0, bus_error_out},64'd0);
      chk("lhu_rw",     {63'd0, RegWrite_out}, 64'd1);
      tick(); bubble();

      // LW sign extension from upper lane
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 64'h7004, 64'd0, 5'd9);
      #1;
      run_access(1, 1'b1, 64'h8765_4321_0000_0000, stalls);
      chk("lw_stalls", 64'(stalls),  64'd3);
      chk("lw_data",   mem_data_out, 64'hFFFF_FFFF_8765_4321);
      tick(); bubble();

      // SW at upper word
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 64'h3004, 64'h0000_0000_CAFE_BABE, 5'd0);
      #1;
      run_access(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, stalls);
      chk("sw_wstrb", {56'd0, b_wstrb},        64'h0000_0000_0000_00F0);
      chk("sw_wdata", b_wdata,                 64'hCAFE_BABE_0000_0000);
      chk("sw_we",    {63'd0, b_we},           64'd1);
      chk("sw_addr",  b_addr,                  64'h3000);
      chk("sw_rw",    {63'd0, RegWrite_out},   64'd0);
      chk("sw_mdata", mem_data_out,            64'd0);
      tick(); bubble();

      // SB to lane 5
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 64'h8005, 64'h1122_3344_5566_77AB, 5'd0);
      #1;
      run_access(0, 1'b1, 64'd0, stalls);
      chk("sb_wstrb", {56'd0, b_wstrb}, 64'h20);
      chk("sb_wdata", b_wdata,          64'h6677_AB00_0000_0000);
      tick(); bubble();

      // Misaligned LD
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 64'h4004, 64'd0, 5'd3);
      #1;
      chk("mis_pulse", {63'd0, misaligned_out}, 64'd1);
      chk("mis_stall", {63'd0, stall_out},      64'd0);
      chk("mis_rw",    {63'd0, RegWrite_out},   64'd0);
      tick();
      chk("mis_req",   {63'd0, dmem_req},       64'd0);
      bubble();
      #1;
      chk("mis_clear", {63'd0, misaligned_out}, 64'd0);

      // Illegal encodings: funct3=111 load, unsigned-size store
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 64'h4000, 64'd0, 5'd3);
      #1;
      chk("ill_f3",    {63'd0, misaligned_out}, 64'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 64'h4000, 64'd0, 5'd0);
      #1;
      chk("ill_st",    {63'd0, misaligned_out}, 64'd1);
      chk("ill_stall", {63'd0, stall_out},      64'd0);
      tick(); bubble();

      // Timeout: no ack for ACK_TIMEOUT BUSY cycles
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 64'h6000, 64'd0, 5'd4);
      #1;
      run_access(0, 1'b0, 64'd0, stalls);
      chk("to_stalls", 64'(stalls),             64'd5);
      chk("to_berr",   {63'd0, bus_error_out},  64'd1);
      chk("to_rw",     {63'd0, RegWrite_out},   64'd0);
      chk("to_req",    {63'd0, dmem_req},       64'd0);
      tick(); bubble();
      #1;
      chk("to_berr_off", {63'd0, bus_error_out}, 64'd0);

      // Reset in BUSY, then a late ack
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 64'h5000, 64'd0, 5'd6);
      tick();
      chk("rb_req_busy", {63'd0, dmem_req}, 64'd1);
      #2;
      bubble();
      reset = 1'b1;
      #1;
      chk("rb_req_rst", {63'd0, dmem_req}, 64'd0);
      tick();
      reset = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      dmem_ack = 1'b0;
      chk("rb_late_req",   {63'd0, dmem_req},      64'd0);
      chk("rb_late_stall", {63'd0, stall_out},     64'd0);
      chk("rb_late_data",  mem_data_out,           64'd0);
      chk("rb_late_berr",  {63'd0, bus_error_out}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
